instr_fetch_unit: RTL and testbench

- Parametrised instruction-fetch and issue block. It holds a loadable program memory and a program counter, and issues instruction words to the core's decoder over a valid/ready handshake.
- Stops at a configurable end-of-program word (16'h0000 by default) and accepts taken-branch redirects from the core at issue time.
- Sits between the program-load path and the top-level instruction input of the processor. It replaces hand-driven instruction sequencing.

---
 rtl/instr_fetch_unit_if.sv | 21 ++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction issue handshake between the fetch unit and the core decoder.
// The master offers instr/instr_valid; the slave answers with instr_ready.
interface instr_fetch_unit_if #(
    parameter int INSTR_WIDTH = 16
);
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   instr_ready;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue: loadable program memory, PC, halt detection
// and valid/ready issue to the core with taken-branch redirects.
module instr_fetch_unit #(
    parameter int                     INSTR_WIDTH = 16,
    parameter int                     ADDR_WIDTH  = 6,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = '0,
    parameter int                     CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   i_prog_we,
    input  logic [ADDR_WIDTH-1:0]  i_prog_addr,
    input  logic [INSTR_WIDTH-1:0] i_prog_data,
    input  logic                   i_pc_load,
    input  logic [ADDR_WIDTH-1:0]  i_pc_target,
    instr_fetch_unit_if.master     fetch,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic                   o_busy,
    output logic                   o_halted,
    output logic [CNT_WIDTH-1:0]   o_issued_cnt
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECIDE,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
    logic [INSTR_WIDTH-1:0] r_rdata;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   r_valid;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [ADDR_WIDTH-1:0]  w_pc_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   w_hs;
    logic                   w_mem_we;
    logic                   w_is_halt;

    assign w_hs      = r_valid && fetch.instr_ready;
    assign w_is_halt = (r_rdata == HALT_WORD);
    assign w_mem_we  = i_prog_we &&
                       ((r_state == S_IDLE) || (r_state == S_HALT));

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        unique case (r_state)
            S_IDLE: begin
                if (i_pc_load) w_pc_nxt = i_pc_target;
                if (i_start) w_state_nxt = S_FETCH;
            end
            S_FETCH: w_state_nxt = S_DECIDE;
            S_DECIDE: begin
                w_state_nxt = w_is_halt ? S_HALT : S_ISSUE;
            end
            S_ISSUE: begin
                // Redirects only take effect together with an accept
                if (w_hs) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = i_pc_load ? i_pc_target
                                            : r_pc + ADDR_WIDTH'(1);
                end
            end
            S_HALT: begin
                if (i_pc_load) w_pc_nxt = i_pc_target;
                if (i_start) w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_pc <= w_pc_nxt;
            if (r_state == S_DECIDE && !w_is_halt) begin
                r_instr <= r_rdata;
                r_valid <= 1'b1;
            end
            if (w_hs) begin
                r_valid <= 1'b0;
                r_cnt   <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Program memory is not reset; writes never overlap a read
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[i_prog_addr] <= i_prog_data;
        if (r_state == S_FETCH) r_rdata <= r_mem[r_pc];
    end

    assign fetch.instr       = r_instr;
    assign fetch.instr_valid = r_valid;
    assign o_pc              = r_pc;
    assign o_issued_cnt      = r_cnt;
    assign o_halted          = (r_state == S_HALT);
    assign o_busy            = (r_state == S_FETCH) ||
                               (r_state == S_DECIDE) ||
                               (r_state == S_ISSUE);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed programs, expected
// words queued by the stimulus and popped by a negedge monitor.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        pc_load = 1'b0;
    logic [5:0]  pc_target = '0;
    logic [5:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] issued_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_hs = -1;
    bit          chk_gap = 1'b0;
    bit          stalled = 1'b0;
    logic [15:0] held;
    logic [15:0] exp_q[$];

    instr_fetch_unit_if #(.INSTR_WIDTH(16)) fif ();

    instr_fetch_unit #(
        .INSTR_WIDTH(16),
        .ADDR_WIDTH (6),
        .HALT_WORD  (16'h0000),
        .CNT_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_prog_we   (prog_we),
        .i_prog_addr (prog_addr),
        .i_prog_data (prog_data),
        .i_pc_load   (pc_load),
        .i_pc_target (pc_target),
        .fetch       (fif),
        .o_pc        (pc),
        .o_busy      (busy),
        .o_halted    (halted),
        .o_issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!chk_gap) last_hs = -1;
        if (rst || fif.instr_valid !== 1'b1) begin
            stalled = 1'b0;
        end else begin
            chk("halt_word_hidden", 32'(fif.instr != 16'h0000), 1);
            if (stalled) chk("stall_stable", fif.instr, held);
            if (fif.instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got 0x%0h expected none",
                             fif.instr);
                end else begin
                    chk("issue_word", fif.instr, exp_q.pop_front());
                end
                if (chk_gap && last_hs >= 0)
                    chk("issue_gap", cyc - last_hs, 3);
                last_hs = cyc;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = fif.instr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_valid", fif.instr_valid, 0);
        chk("rst_instr", fif.instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", issued_cnt, 0);
        rst = 1'b0;
        tick();
    endtask

    task automatic load(input logic [5:0] a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (fif.instr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(name, fif.instr_valid, 1);
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (halted !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        chk(name, halted, 1);
    endtask

    task automatic sb_drained(input string name);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        fif.instr_ready = 1'b0;
        tick();
        do_reset();

        // 1: straight-line program, ready held high
        load(6'd0, 16'h4142);
        load(6'd1, 16'h4402);
        load(6'd2, 16'h0253);
        load(6'd3, 16'h0291);
        load(6'd4, 16'h0000);
        exp_q = '{16'h4142, 16'h4402, 16'h0253, 16'h0291};
        fif.instr_ready = 1'b1;
        chk_gap = 1'b1;
        pulse_start();
        chk("t1_busy", busy, 1);
        chk("t1_lat1", fif.instr_valid, 0);
        tick();
        chk("t1_lat2", fif.instr_valid, 0);
        tick();
        chk("t1_lat3", fif.instr_valid, 1);
        chk("t1_first", fif.instr, 16'h4142);
        wait_halt("t1_halt");
        chk_gap = 1'b0;
        chk("t1_pc", pc, 4);
        chk("t1_cnt", issued_cnt, 4);
        chk("t1_busy_halt", busy, 0);
        sb_drained("t1_sb");

        // 2: stall on the second word
        do_reset();
        fif.instr_ready = 1'b0;
        exp_q = '{16'h4142, 16'h4402, 16'h0253, 16'h0291};
        pulse_start();
        wait_valid("t2_v0");
        fif.instr_ready = 1'b1;
        tick();
        fif.instr_ready = 1'b0;
        wait_valid("t2_v1");
        repeat (5) tick();
        chk("t2_stall_valid", fif.instr_valid, 1);
        chk("t2_stall_word", fif.instr, 16'h4402);
        chk("t2_stall_cnt", issued_cnt, 1);
        fif.instr_ready = 1'b1;
        tick();
        chk("t2_accept_cnt", issued_cnt, 2);
        chk("t2_accept_drop", fif.instr_valid, 0);
        wait_halt("t2_halt");
        chk("t2_cnt", issued_cnt, 4);
        sb_drained("t2_sb");

        // 3: redirect to address 3 on the first handshake
        do_reset();
        fif.instr_ready = 1'b0;
        exp_q = '{16'h4142, 16'h0291};
        pulse_start();
        wait_valid("t3_v0");
        pc_load   = 1'b1;
        pc_target = 6'd3;
        fif.instr_ready = 1'b1;
        tick();
        pc_load = 1'b0;
        chk("t3_pc_redirect", pc, 3);
        wait_halt("t3_halt");
        chk("t3_cnt", issued_cnt, 2);
        chk("t3_pc", pc, 4);
        sb_drained("t3_sb");

        // 5: resume from HALT after patching the halt word
        load(6'd4, 16'h0353);
        load(6'd5, 16'h0000);
        exp_q = '{16'h0353};
        pulse_start();
        chk("t5_halt_clear", halted, 0);
        tick();
        chk("t5_lat2", fif.instr_valid, 0);
        tick();
        chk("t5_valid", fif.instr_valid, 1);
        chk("t5_word", fif.instr, 16'h0353);
        wait_halt("t5_halt");
        chk("t5_pc", pc, 5);
        chk("t5_cnt", issued_cnt, 3);
        sb_drained("t5_sb");

        // 4: PC wrap from 63 to 0
        do_reset();
        load(6'd63, 16'h0253);
        load(6'd0, 16'h0291);
        load(6'd1, 16'h0000);
        pc_load   = 1'b1;
        pc_target = 6'd63;
        tick();
        pc_load = 1'b0;
        chk("t4_pc_load", pc, 63);
        exp_q = '{16'h0253, 16'h0291};
        fif.instr_ready = 1'b1;
        pulse_start();
        wait_halt("t4_halt");
        chk("t4_pc", pc, 1);
        chk("t4_cnt", issued_cnt, 2);
        sb_drained("t4_sb");

        // 6: write ignored in ISSUE, then reset aborts the offer
        do_reset();
        fif.instr_ready = 1'b0;
        pulse_start();
        wait_valid("t6_v0");
        chk("t6_word", fif.instr, 16'h0291);
        load(6'd1, 16'h1111);
        chk("t6_still_valid", fif.instr_valid, 1);
        do_reset();
        exp_q = '{16'h0291};
        fif.instr_ready = 1'b1;
        pulse_start();
        wait_halt("t6_halt");
        chk("t6_pc", pc, 1);
        chk("t6_cnt", issued_cnt, 1);
        sb_drained("t6_sb");

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
